// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word, NOP and fetch/IF-ID types
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t npc;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP, npc: 32'h0000_0000};

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// rtl/fetch_stage_ifid_reg.sv - IF/ID pipeline latch with load, hold and flush
module ifid_reg
  import cpu_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_npc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] npc
);

  ifid_t entry;

  // Flush outranks load so a squashed slot can never carry a wrong-path word.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      entry <= IFID_BUBBLE;
    end else if (load) begin
      entry <= '{valid: 1'b1, instr: next_instr, npc: next_npc};
    end
  end

  assign valid = entry.valid;
  assign instr = entry.instr;
  assign npc   = entry.npc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, icache request, IF/ID latch, sticky halt
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_halt,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_t state, state_next;
  word_t        pc, pc_plus4, count;
  logic         take_redirect, take_halt, take_hit, take_miss, ifid_flush;

  assign pc_plus4 = pc + 32'd4;

  // Priority decode: redirect, halt, stall, hit, miss. Nothing acts while halted.
  always_comb begin
    take_redirect = 1'b0;
    take_halt     = 1'b0;
    take_hit      = 1'b0;
    take_miss     = 1'b0;
    if (state == RUN) begin
      if (redirect) begin
        take_redirect = 1'b1;
      end else if (id_halt && !stall) begin
        take_halt = 1'b1;
      end else if (!stall) begin
        take_hit  = ihit;
        take_miss = !ihit;
      end
    end
  end

  assign ifid_flush = take_redirect | take_halt | take_miss;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (state == RUN && take_halt) begin
      state_next = HALTED;
    end
  end

  always_comb begin
    imemREN = (state == RUN);
    halted  = (state == HALTED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc <= PC_INIT;
    end else if (take_redirect) begin
      pc <= redirect_pc;
    end else if (take_hit) begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= 32'd0;
    end else if (take_hit) begin
      count <= count + 32'd1;
    end
  end

  ifid_reg u_ifid_reg (
    .clk        (CLK),
    .rst        (RST),
    .load       (take_hit),
    .flush      (ifid_flush),
    .next_instr (imemload),
    .next_npc   (pc_plus4),
    .valid      (ifid_valid),
    .instr      (ifid_instr),
    .npc        (ifid_npc)
  );

  assign imemaddr    = pc;
  assign fetch_count = count;

endmodule
